// File: rtl/fx_pkg.sv
// Shared types, widths and the delay-clamp helper for the fx delay path.
package fx_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int DEF_ADDR_W = 10;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // A delay of 0 would read the slot being written, so the floor is 1.
  function automatic int unsigned clampDelay(input int unsigned total,
                                             input int unsigned maxDelay);
    if (total < 1) return 1;
    if (total > maxDelay) return maxDelay;
    return total;
  endfunction

endpackage

// File: rtl/fx_delay_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Read data appears the cycle after rdEn; contents are not reset.
module fx_delay_ram
  import fx_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                wrEn,
  input  logic [ADDR_W-1:0]   wrAddr,
  input  logic [SAMPLE_W-1:0] wrDat,
  input  logic                rdEn,
  input  logic [ADDR_W-1:0]   rdAddr,
  output logic [SAMPLE_W-1:0] rdDat
);

  logic [SAMPLE_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrDat;
    if (rdEn) rdDat <= mem[rdAddr];
  end

endmodule

// File: rtl/fx_delay_line.sv
// Circular-buffer delay: dry sample plus the sample written `delay` samples earlier; 2-cycle latency, no backpressure.
// Optional PHASER_LFO_EN adds a triangle LFO offset to the requested delay.
module fx_delay_line
  import fx_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LFO_DIV   = 64,
  parameter int LFO_DEPTH = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_audio,
  input  logic [ADDR_W-1:0]   delay,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_dry,
  output logic [SAMPLE_W-1:0] out_del
);

  localparam int unsigned MAX_DELAY = (2**ADDR_W) - 1;

  logic                accept;
  logic [ADDR_W:0]     delayTotal;
  logic [ADDR_W-1:0]   eff;
  logic [ADDR_W-1:0]   wrPtr;
  logic [ADDR_W-1:0]   fill;
  logic [ADDR_W-1:0]   rdAddr;
  logic [SAMPLE_W-1:0] ramRdDat;
  logic                s1Vld;
  logic                s1Use;
  logic [SAMPLE_W-1:0] s1Dry;

  assign accept = in_valid && !rst;

`ifdef PHASER_LFO_EN
  localparam int DIV_W = (LFO_DIV > 1) ? $clog2(LFO_DIV) : 1;

  logic [DIV_W-1:0]  divCnt;
  logic [ADDR_W-1:0] lfo;
  logic              lfoDown;

  assign delayTotal = {1'b0, delay} + {1'b0, lfo};

  // The current sample uses the LFO value before this step.
  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt  <= '0;
      lfo     <= '0;
      lfoDown <= 1'b0;
    end else if (in_valid) begin
      if (divCnt == DIV_W'(LFO_DIV - 1)) begin
        divCnt <= '0;
        if (lfoDown) begin
          lfo <= lfo - 1'b1;
          if (lfo == ADDR_W'(1)) lfoDown <= 1'b0;
        end else begin
          lfo <= lfo + 1'b1;
          if (lfo == ADDR_W'(LFO_DEPTH - 1)) lfoDown <= 1'b1;
        end
      end else begin
        divCnt <= divCnt + 1'b1;
      end
    end
  end
`else
  // LFO parameters have no effect without the feature.
  localparam int unusedLfoCfg = LFO_DIV + LFO_DEPTH;

  assign delayTotal = {1'b0, delay};
`endif

  assign eff    = ADDR_W'(clampDelay(32'(delayTotal), MAX_DELAY));
  assign rdAddr = wrPtr - eff;

  fx_delay_ram #(
    .ADDR_W(ADDR_W)
  ) uRam (
    .clk    (clk),
    .wrEn   (accept),
    .wrAddr (wrPtr),
    .wrDat  (in_audio),
    .rdEn   (accept),
    .rdAddr (rdAddr),
    .rdDat  (ramRdDat)
  );

  // fill is compared before it advances, so the first sample never sees stale RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr     <= '0;
      fill      <= '0;
      s1Vld     <= 1'b0;
      s1Use     <= 1'b0;
      s1Dry     <= '0;
      out_valid <= 1'b0;
      out_dry   <= '0;
      out_del   <= '0;
    end else begin
      s1Vld     <= in_valid;
      out_valid <= s1Vld;
      if (in_valid) begin
        s1Dry <= in_audio;
        s1Use <= en && (eff <= fill);
        wrPtr <= wrPtr + 1'b1;
        if (fill != '1) fill <= fill + 1'b1;
      end
      if (s1Vld) begin
        out_dry <= s1Dry;
        out_del <= s1Use ? ramRdDat : '0;
      end
    end
  end

endmodule

// File: tb/tb_fx_delay_line.sv
// Scoreboard bench for fx_delay_line at ADDR_W=4 (depth 16, max delay 15).
module tb_fx_delay_line;

  localparam int AW = 4;

  typedef struct {
    logic [15:0] dry;
    logic [15:0] del;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   in_audio = '0;
  logic [AW-1:0] delay = '0;
  logic          out_valid;
  logic [15:0]   out_dry;
  logic [15:0]   out_del;

  exp_t        sb[$];
  logic [15:0] hist[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          lfoSeq[6] = '{0, 1, 2, 3, 2, 1};

`ifdef PHASER_LFO_EN
  fx_delay_line #(.ADDR_W(AW), .LFO_DIV(1), .LFO_DEPTH(3)) dut (
`else
  fx_delay_line #(.ADDR_W(AW)) dut (
`endif
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_audio  (in_audio),
    .delay     (delay),
    .out_valid (out_valid),
    .out_dry   (out_dry),
    .out_del   (out_del)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected delayed sample comes from the history of samples written since reset.
  task automatic send(input logic [15:0] s, input logic [AW-1:0] d,
                      input logic e, input int lfoOff);
    int   effT;
    exp_t x;
    effT = int'(d) + lfoOff;
    if (effT < 1) effT = 1;
    if (effT > 15) effT = 15;
    x.dry = s;
    x.del = (e && effT <= hist.size()) ? hist[hist.size() - effT] : 16'd0;
    x.cyc = cyc + 2;
    sb.push_back(x);
    hist.push_back(s);
    in_valid = 1'b1;
    in_audio = s;
    delay    = d;
    en       = e;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Drops expectations that the reset edge will kill, then holds reset.
  task automatic doReset(input int n, input logic withInput, input logic [15:0] s);
    while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
    rst      = 1'b1;
    in_valid = withInput;
    in_audio = s;
    repeat (n) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    hist.delete();
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected out_valid: got out_dry=%0d out_del=%0d, expected none (cycle %0d)",
                 out_dry, out_del, cyc);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("latency", cyc, x.cyc);
        chk("out_dry", int'(out_dry), int'(x.dry));
        chk("out_del", int'(out_del), int'(x.del));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_dry", int'(out_dry), 0);
    chk("reset out_del", int'(out_del), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef PHASER_LFO_EN
    // Effective delay walks 2,3,4,5,4,3,2,... with the triangle LFO.
    for (int k = 0; k < 20; k++) send(16'(k + 1), AW'(2), 1'b1, lfoSeq[k % 6]);
`else
    // delay=4: first four outputs are masked, then out_del = sample-4.
    for (int k = 1; k <= 8; k++) send(16'(k), AW'(4), 1'b1, 0);

    // delay=0 clamps to 1.
    doReset(2, 1'b0, 16'd0);
    send(16'd100, AW'(0), 1'b1, 0);
    send(16'd200, AW'(0), 1'b1, 0);

    // Maximum delay across two pointer wraps.
    doReset(2, 1'b0, 16'd0);
    for (int k = 0; k < 40; k++) send(16'(k), AW'(15), 1'b1, 0);

    // Same stream with en low for samples 20..24.
    doReset(2, 1'b0, 16'd0);
    for (int k = 0; k < 40; k++) send(16'(k), AW'(15), !(k >= 20 && k <= 24), 0);

    // Reset mid-stream with one sample in flight and one arriving with reset.
    doReset(2, 1'b0, 16'd0);
    for (int k = 1; k <= 10; k++) send(16'(k), AW'(4), 1'b1, 0);
    doReset(1, 1'b1, 16'd11);
    for (int k = 50; k <= 55; k++) send(16'(k), AW'(4), 1'b1, 0);
`endif

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drain pending", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fx_delay_line.md
Name: fx_delay_line

Overview:
- Produces the delayed sample stream (`del_audio`) that the fx mixer sums with, or subtracts from, the dry input.
- Stores incoming 16-bit audio samples in a circular buffer.
- Returns each new dry sample together with the sample written a programmable number of samples earlier, both aligned under one valid strobe.
- Sits between the audio sample source and the fx mixer.

Parameters:
- ADDR_W, 10, buffer address width; depth = 2^ADDR_W samples (default 1024).
- LFO_DIV, 64, input samples per LFO step (used only with PHASER_LFO_EN).
- LFO_DEPTH, 255, peak LFO offset in samples (used only with PHASER_LFO_EN); must be ≤ 2^ADDR_W-2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = delay active; 0 = `out_del` forced to 0, buffer still written.
- in_valid  in  1  one-cycle strobe; `in_audio` is valid this cycle.
- in_audio  in  16  dry sample (two's-complement, passed through unchanged).
- delay  in  ADDR_W  requested delay in samples; sampled on each `in_valid`.
- out_valid  out  1  one-cycle strobe; `out_dry` and `out_del` are valid.
- out_dry  out  16  dry sample aligned with `out_del`.
- out_del  out  16  delayed sample, to the mixer's `delAudio` input.

Behaviour:
- Reset values: `out_valid`=0, `out_dry`=0, `out_del`=0, wr_ptr=0, fill=0, pipeline valids=0, LFO state=0.
- Buffer RAM contents are not cleared by reset; the fill counter masks stale data.
- Stage 0, cycle of `in_valid`=1:
  - write `in_audio` to mem[wr_ptr];
  - compute eff = clamp(delay_total, 1, 2^ADDR_W-1); delay_total = `delay` (plus LFO offset with the feature);
  - rd_addr = wr_ptr - eff, modulo 2^ADDR_W (natural wrap);
  - latch `in_audio`, eff, and `en` into stage-1 registers;
  - wr_ptr increments, wrapping 2^ADDR_W-1 → 0;
  - fill increments, saturating at 2^ADDR_W-1.
- Stage 1: registered synchronous read of mem[rd_addr].
- Stage 2:
  - `out_valid`=1;
  - `out_dry` = latched sample;
  - `out_del` = RAM data if (en && eff ≤ fill_at_write), else 0.
- Latency: exactly 2 cycles from `in_valid` to `out_valid`. Back-to-back `in_valid` is accepted every cycle at full throughput. There is no backpressure.
- fill_at_write is the fill value before the current write, so the first sample after reset always yields `out_del`=0.
- Delay clamp: `delay`=0 behaves as 1. Because eff ≥ 1, the read address never equals the write address in the same cycle, so no RAM collision handling is needed.
- `delay` or `en` changing between samples takes effect on the next `in_valid`; there are no glitches mid-pipeline.
- `out_del` is the raw stored sample. Sum/difference and saturation remain the mixer's job.
- rst asserted mid-operation: in-flight samples are discarded (`out_valid` stays 0 the next cycle) and wr_ptr and fill return to 0.
- `in_valid` in the same cycle as rst is ignored.

Optional Feature:
- Macro: PHASER_LFO_EN.
- Defined:
  - a triangle LFO counter lfo (ADDR_W bits) plus a direction bit are added;
  - a sample divider counts `in_valid` pulses; every LFO_DIV-th pulse, lfo steps ±1;
  - at lfo=LFO_DEPTH the direction flips to down; at lfo=0 it flips to up (no overshoot);
  - delay_total = `delay` + lfo, computed ADDR_W+1 bits wide, then clamped per the rules above;
  - LFO state resets to 0 with direction up.
- Not defined: delay_total = `delay`; no LFO logic is present.

Decomposition:
- Shared package fx_pkg:
  - SAMPLE_W=16;
  - audio sample typedef (signed 16-bit);
  - default ADDR_W constant;
  - the delay-clamp helper function.
- One sub-module, fx_delay_ram: simple dual-port RAM (1 write port, 1 registered read port, depth 2^ADDR_W × 16), written so it infers block RAM.
- The LFO stays inline.

Test Plan:
- Reset, then in_valid every cycle with in_audio=1,2,3,…, delay=4, en=1 → out_valid 2 cycles after each input; out_del=0 for the first 4 outputs; output #5 has out_dry=5 and out_del=1.
- delay=0, samples 100 then 200 → second output has out_dry=200 and out_del=100 (clamped to 1).
- ADDR_W=4, delay=15, 40 consecutive samples 0..39 → output for sample k≥15 has out_del=k-15; correct across two pointer wraps.
- Same stream with en=0 for samples 20–24 → out_del=0 for exactly those outputs; out_dry unchanged; output for sample 25 has out_del=10.
- rst pulsed for one cycle after sample 10 while two samples are in flight → no out_valid for those two; next sample (delay=4) gives out_del=0 until 4 new samples have been written.
- PHASER_LFO_EN, LFO_DIV=1, LFO_DEPTH=3, delay=2 → eff sequence 2,3,4,5,4,3,2,3… over successive samples once the buffer is filled.
